// File: rtl/feeder_pkg.sv
// Shared types, defaults and helpers for the number feeder.
package feeder_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_GAP
    } feeder_state_t;

    localparam int unsigned DATA_W_DEF = 8;

    // Like $clog2 but never returns 0, so a derived width is always legal.
    function automatic int unsigned clog2_safe(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/number_feeder_if.sv
// Handshake input and classifier-facing outputs of the number feeder.
interface number_feeder_if #(
    parameter int unsigned DATA_W = feeder_pkg::DATA_W_DEF,
    parameter int unsigned DEPTH  = 4
);
    logic [DATA_W-1:0]      in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      number;
    logic                   present;
    logic                   start_pulse;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   zero_seen;

    // Producer side: drives candidate numbers, observes status.
    modport master (
        output in_data, in_valid,
        input  in_ready, number, present, start_pulse, fifo_count, zero_seen
    );

    // Feeder side.
    modport slave (
        input  in_data, in_valid,
        output in_ready, number, present, start_pulse, fifo_count, zero_seen
    );
endinterface

// File: rtl/feeder_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata always shows the head entry.
module feeder_fifo
    import feeder_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DATA_W-1:0]      wdata,
    input  logic                   pop,
    output logic [DATA_W-1:0]      rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PTR_W = clog2_safe(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/number_feeder.sv
// Buffers incoming numbers and presents each one to the classifier for a fixed
// hold window followed by a zero gap that returns the classifier to idle.
module number_feeder
    import feeder_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 6,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input logic            clk,
    input logic            rst,
    number_feeder_if.slave bus
);
    localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned TMR_W   = clog2_safe(CNT_MAX + 1);

    feeder_state_t          state_q;
    logic [DATA_W-1:0]      number_q;
    logic                   present_q;
    logic                   start_q;
    logic                   zero_seen_q;
    logic [TMR_W-1:0]       hold_cnt_q;
    logic [TMR_W-1:0]       gap_cnt_q;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_W-1:0]      fifo_rdata;
    logic [$clog2(DEPTH):0] fifo_cnt;
    logic                   accept;
    logic                   push;
    logic                   pop;

    // Ready is held low during reset so nothing is accepted into a flushing FIFO.
    assign bus.in_ready = !fifo_full && !rst;
    assign accept       = bus.in_valid && bus.in_ready;
    // Zeros complete the handshake but are never stored.
    assign push         = accept && (bus.in_data != '0);
    assign pop          = (state_q == S_IDLE) && !fifo_empty;

    assign bus.number      = number_q;
    assign bus.present     = present_q;
    assign bus.start_pulse = start_q;
    assign bus.fifo_count  = fifo_cnt;
    assign bus.zero_seen   = zero_seen_q;

    feeder_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (bus.in_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // Sticky flag for dropped zero inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_seen_q <= 1'b0;
        end else if (accept && (bus.in_data == '0)) begin
            zero_seen_q <= 1'b1;
        end
    end

    // Presentation FSM: pop, hold for HOLD_CYCLES, then zero for GAP_CYCLES.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            number_q   <= '0;
            present_q  <= 1'b0;
            start_q    <= 1'b0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        number_q   <= fifo_rdata;
                        present_q  <= 1'b1;
                        start_q    <= 1'b1;
                        hold_cnt_q <= TMR_W'(HOLD_CYCLES - 1);
                        state_q    <= S_HOLD;
                    end else begin
                        number_q <= '0;
                    end
                end
                S_HOLD: begin
                    start_q <= 1'b0;
                    if (hold_cnt_q == '0) begin
                        number_q  <= '0;
                        present_q <= 1'b0;
                        gap_cnt_q <= TMR_W'(GAP_CYCLES - 1);
                        state_q   <= S_GAP;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_number_feeder.sv
// Self-checking bench for number_feeder: scoreboard of accepted nonzero values
// against each presented number, plus per-scenario timing checks.
module tb_number_feeder;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned HOLD   = 6;
    localparam int unsigned GAP    = 2;
    localparam int          PERIOD = HOLD + GAP + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    number_feeder_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    number_feeder #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_front;
    int pulse_cyc[$];

    // Record every accepted nonzero value; a reset edge flushes the expectation.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            exp_q.delete();
        end else if (bus.in_valid && bus.in_ready && (bus.in_data != 8'h00)) begin
            exp_q.push_back(bus.in_data);
        end
    end

    // Each start pulse must present the oldest accepted nonzero value.
    always @(negedge clk) begin
        if (bus.start_pulse === 1'b1) begin
            pulse_cyc.push_back(cyc);
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard: presented %02h, required no presentation", bus.number);
            end else begin
                exp_front = exp_q.pop_front();
                if (bus.number !== exp_front)
                    $display("FAIL scoreboard: number=%02h, required %02h", bus.number, exp_front);
                else
                    n_pass++;
            end
        end
    end

    task automatic send(input logic [7:0] d);
        logic ok;
        ok = 1'b0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("FAIL send_timeout: %02h not accepted, required acceptance", d);
        end
    endtask

    task automatic drain();
        int quiet;
        quiet = 0;
        for (int i = 0; i < 300 && quiet < PERIOD + 1; i++) begin
            @(negedge clk);
            if (bus.fifo_count == 0 && bus.present == 1'b0) quiet++;
            else quiet = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL rst_ready: got %b, required 0", bus.in_ready);
        else n_pass++;
        n_checks++;
        if (bus.number !== 8'h00 || bus.present !== 1'b0 || bus.start_pulse !== 1'b0)
            $display("FAIL rst_outputs: number=%02h present=%b start=%b, required 00/0/0",
                     bus.number, bus.present, bus.start_pulse);
        else n_pass++;
        n_checks++;
        if (bus.fifo_count !== 3'd0 || bus.zero_seen !== 1'b0)
            $display("FAIL rst_status: count=%0d zero_seen=%b, required 0/0",
                     bus.fifo_count, bus.zero_seen);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL post_rst_ready: got %b, required 1", bus.in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int hold;
        int sp;
        logic done;
        send(8'h2A);
        @(negedge clk);
        n_checks++;
        if (bus.fifo_count !== 3'd1 || bus.number !== 8'h00)
            $display("FAIL single_accept: count=%0d number=%02h, required 1/00",
                     bus.fifo_count, bus.number);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.number !== 8'h2A || bus.present !== 1'b1 || bus.start_pulse !== 1'b1)
            $display("FAIL single_first: number=%02h present=%b start=%b, required 2a/1/1",
                     bus.number, bus.present, bus.start_pulse);
        else n_pass++;
        hold = 1;
        sp   = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.number === 8'h2A) begin
                hold++;
                sp += int'(bus.start_pulse);
            end else begin
                done = 1'b1;
            end
        end
        n_checks++;
        if (hold != HOLD) $display("FAIL single_hold: held %0d cycles, required %0d", hold, HOLD);
        else n_pass++;
        n_checks++;
        if (sp != 0) $display("FAIL single_pulse_width: extra pulses %0d, required 0", sp);
        else n_pass++;
        n_checks++;
        if (bus.number !== 8'h00 || bus.present !== 1'b0)
            $display("FAIL single_gap1: number=%02h present=%b, required 00/0",
                     bus.number, bus.present);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.number !== 8'h00) $display("FAIL single_gap2: number=%02h, required 00", bus.number);
        else n_pass++;
        drain();
    endtask

    task automatic test_back_to_back();
        pulse_cyc.delete();
        send(8'h81);
        send(8'h02);
        send(8'h7F);
        send(8'h10);
        send(8'h33);
        @(negedge clk);
        n_checks++;
        if (bus.fifo_count !== 3'd4 || bus.in_ready !== 1'b0)
            $display("FAIL b2b_full: count=%0d ready=%b, required 4/0",
                     bus.fifo_count, bus.in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_stall();
        logic [7:0] junk [3];
        junk[0] = 8'h55;
        junk[1] = 8'h66;
        junk[2] = 8'h77;
        for (int i = 0; i < 3; i++) begin
            bus.in_data  = junk[i];
            bus.in_valid = 1'b1;
            @(negedge clk);
            n_checks++;
            if (bus.fifo_count !== 3'd4 || bus.in_ready !== 1'b0)
                $display("FAIL stall_%0d: count=%0d ready=%b, required 4/0",
                         i, bus.fifo_count, bus.in_ready);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 100 && pulse_cyc.size() < 5; i++) @(negedge clk);
        n_checks++;
        if (pulse_cyc.size() != 5)
            $display("FAIL b2b_pulses: %0d presentations, required 5", pulse_cyc.size());
        else n_pass++;
        for (int i = 1; i < pulse_cyc.size(); i++) begin
            n_checks++;
            if (pulse_cyc[i] - pulse_cyc[i-1] != PERIOD)
                $display("FAIL b2b_period_%0d: %0d cycles, required %0d",
                         i, pulse_cyc[i] - pulse_cyc[i-1], PERIOD);
            else n_pass++;
        end
        drain();
    endtask

    task automatic test_zero_filter();
        int max_cnt;
        pulse_cyc.delete();
        n_checks++;
        if (bus.zero_seen !== 1'b0) $display("FAIL zero_pre: got %b, required 0", bus.zero_seen);
        else n_pass++;
        send(8'h00);
        @(negedge clk);
        n_checks++;
        if (bus.zero_seen !== 1'b1 || bus.fifo_count !== 3'd0)
            $display("FAIL zero_drop: zero_seen=%b count=%0d, required 1/0",
                     bus.zero_seen, bus.fifo_count);
        else n_pass++;
        @(posedge clk);
        #1;
        send(8'h05);
        max_cnt = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge clk);
            if (int'(bus.fifo_count) > max_cnt) max_cnt = int'(bus.fifo_count);
        end
        n_checks++;
        if (max_cnt > 1) $display("FAIL zero_count: max count %0d, required <= 1", max_cnt);
        else n_pass++;
        n_checks++;
        if (pulse_cyc.size() != 1)
            $display("FAIL zero_pulses: %0d presentations, required 1", pulse_cyc.size());
        else n_pass++;
        drain();
    endtask

    task automatic test_reset_mid_hold();
        pulse_cyc.delete();
        send(8'h44);
        send(8'h11);
        send(8'h22);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.number !== 8'h44 || bus.fifo_count !== 3'd2)
            $display("FAIL midrst_pre: number=%02h count=%0d, required 44/2",
                     bus.number, bus.fifo_count);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.number !== 8'h00 || bus.present !== 1'b0 || bus.fifo_count !== 3'd0)
            $display("FAIL midrst_post: number=%02h present=%b count=%0d, required 00/0/0",
                     bus.number, bus.present, bus.fifo_count);
        else n_pass++;
        n_checks++;
        if (bus.zero_seen !== 1'b0) $display("FAIL midrst_zero: got %b, required 0", bus.zero_seen);
        else n_pass++;
        repeat (3 * PERIOD) @(negedge clk);
        n_checks++;
        if (pulse_cyc.size() != 1)
            $display("FAIL midrst_stale: %0d presentations, required 1", pulse_cyc.size());
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_pair_once();
        pulse_cyc.delete();
        send(8'h80);
        send(8'h01);
        drain();
        n_checks++;
        if (pulse_cyc.size() != 2)
            $display("FAIL pair_count: %0d presentations, required 2", pulse_cyc.size());
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL pair_leftover: %0d unpresented, required 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_full_stall();
        test_zero_filter();
        test_reset_mid_hold();
        test_pair_once();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
